// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and defaults for the glitch-free clock switch controller.
// The FSM state encoding and the common down-counter type live here.
package clk_switch_ctrl_pkg;

  localparam int unsigned GATE_CYCLES_DEFAULT  = 4;
  localparam int unsigned LOCK_TIMEOUT_DEFAULT = 16;
  localparam int unsigned CNT_W                = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    DRAIN     = 3'd2,
    SWITCH    = 3'd3,
    SETTLE    = 3'd4
  } state_t;

  // Reload value for a phase lasting 'cycles' cycles; phases exit when the count reaches 0.
  function automatic cnt_t phase_load(input int unsigned cycles);
    return (cycles > 1) ? cnt_t'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a downstream two-input clock mux and clock gate: gates the clock,
// changes the select while gated, ungates, and falls back to clk0 when clk1 loses lock.
module clk_switch_ctrl
  import clk_switch_ctrl_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = GATE_CYCLES_DEFAULT,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  input  logic lock_i,
  output logic clk_sel_o,
  output logic clk_en_o,
  output logic done_o,
  output logic err_o,
  output logic fault_o,
  output logic busy_o
);

  localparam cnt_t WAIT_LOAD  = phase_load(LOCK_TIMEOUT);
  localparam cnt_t DRAIN_LOAD = phase_load(GATE_CYCLES);
  // The SWITCH cycle already holds the gate closed, so SETTLE supplies the rest of the
  // post-switch gating; it is kept at least one cycle so select and enable never move together.
  localparam cnt_t SETTLE_LOAD = phase_load((GATE_CYCLES > 1) ? GATE_CYCLES - 1 : 1);
  localparam cnt_t ABORT_LOAD  = phase_load(GATE_CYCLES);

  state_t state_q, state_n;
  cnt_t   cnt_q, cnt_n;
  logic   target_q, target_n;
  logic   abort_q, abort_n;
  logic   sel_n, en_n, done_n, err_n, fault_n;
  logic   accept;

  assign accept = req_valid_i && req_ready_o;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state_q;
    cnt_n    = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    target_n = target_q;
    abort_n  = abort_q;
    sel_n    = clk_sel_o;
    en_n     = clk_en_o;
    done_n   = 1'b0;
    err_n    = 1'b0;
    fault_n  = fault_o;

    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (clk_sel_o && !lock_i) begin
          // Fallback wins over any request presented in the same cycle.
          state_n  = DRAIN;
          cnt_n    = DRAIN_LOAD;
          target_n = 1'b0;
          abort_n  = 1'b0;
          en_n     = 1'b0;
          fault_n  = 1'b1;
        end else if (accept) begin
          fault_n  = 1'b0;
          target_n = req_sel_i;
          abort_n  = 1'b0;
          if (req_sel_i == clk_sel_o) begin
            done_n = 1'b1;
          end else if (req_sel_i) begin
            state_n = WAIT_LOCK;
            cnt_n   = WAIT_LOAD;
          end else begin
            state_n = DRAIN;
            cnt_n   = DRAIN_LOAD;
            en_n    = 1'b0;
          end
        end
      end

      WAIT_LOCK: begin
        if (lock_i) begin
          state_n = DRAIN;
          cnt_n   = DRAIN_LOAD;
          en_n    = 1'b0;
        end else if (cnt_q == '0) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end

      DRAIN: begin
        if (target_q && !lock_i) begin
          state_n = SETTLE;
          cnt_n   = ABORT_LOAD;
          abort_n = 1'b1;
        end else if (cnt_q == '0) begin
          state_n = SWITCH;
          cnt_n   = '0;
        end
      end

      SWITCH: begin
        state_n = SETTLE;
        cnt_n   = SETTLE_LOAD;
        sel_n   = target_q;
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
          en_n    = 1'b1;
          done_n  = !abort_q;
          err_n   = abort_q;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        en_n    = 1'b1;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      target_q    <= 1'b0;
      abort_q     <= 1'b0;
      clk_sel_o   <= 1'b0;
      clk_en_o    <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      fault_o     <= 1'b0;
      busy_o      <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      target_q    <= target_n;
      abort_q     <= abort_n;
      clk_sel_o   <= sel_n;
      clk_en_o    <= en_n;
      done_o      <= done_n;
      err_o       <= err_n;
      fault_o     <= fault_n;
      busy_o      <= (state_n != IDLE);
      req_ready_o <= (state_n == IDLE);
    end
  end

endmodule
